// File: rtl/fx_rob_tag_allocator_pkg.sv
// Shared ROB tag definitions for the rename stage, the ROB and the tag allocator.
// Group sizes are carried minus-one: a 2-bit code 0..3 means 1..4 instructions.
package fx_rob_tag_allocator_pkg;

  localparam int ROB_TAG_W = 7;
  localparam int ROB_DEPTH = 1 << ROB_TAG_W;
  localparam int MAX_INST  = 4;

  typedef logic [1:0]           num_enc_t;
  typedef logic [ROB_TAG_W-1:0] rob_tag_t;
  typedef rob_tag_t [MAX_INST-1:0] tag_bundle_t;

  function automatic logic [2:0] enc_to_num(input num_enc_t enc);
    return {1'b0, enc} + 3'd1;
  endfunction

  // Slot 0 is always the oldest instruction of the group.
  function automatic logic [MAX_INST-1:0] grant_mask(input num_enc_t enc);
    return MAX_INST'((5'b00010 << enc) - 5'd1);
  endfunction

endpackage

// File: rtl/fx_rob_tag_allocator_rob_ptr_adv.sv
// Modular ROB pointer advance by 1..4 entries (minus-one encoded step).
module rob_ptr_adv
  import fx_rob_tag_allocator_pkg::*;
#(
  parameter int W = ROB_TAG_W
) (
  input  logic [W-1:0] ptr,
  input  logic [1:0]   num,
  output logic [W-1:0] next
);

  // The depth is a power of two, so the truncating add is the wrap-around.
  assign next = ptr + W'(enc_to_num(num));

endmodule

// File: rtl/fx_rob_tag_allocator.sv
// Hands out circular ROB tags to up to four renamed instructions per cycle and
// releases them from the head on commit; flush squashes everything in flight.
module fx_rob_tag_allocator
  import fx_rob_tag_allocator_pkg::*;
#(
  parameter int ROBEntryWidth = ROB_TAG_W,
  parameter int maxInst       = MAX_INST
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     allocReq_i,
  input  logic [1:0]               allocNum_i,
  input  logic                     commit_i,
  input  logic [1:0]               commitNum_i,
  input  logic                     flush_i,
  output logic                     allocGrant_o,
  output logic                     allocStall_o,
  output logic [ROBEntryWidth-1:0] inst1Tag_o,
  output logic [ROBEntryWidth-1:0] inst2Tag_o,
  output logic [ROBEntryWidth-1:0] inst3Tag_o,
  output logic [ROBEntryWidth-1:0] inst4Tag_o,
  output logic [3:0]               tagValid_o,
  output logic [ROBEntryWidth-1:0] headPtr_o,
  output logic [ROBEntryWidth:0]   freeCount_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     err_o
);

  localparam int DEPTH = 1 << ROBEntryWidth;
  localparam int CW    = ROBEntryWidth + 1;

  logic [ROBEntryWidth-1:0] head_q, tail_q, head_adv, tail_adv;
  logic [CW-1:0]            count_q, count_d, free;
  logic                     err_q, grant_q, stall_q;
  logic [maxInst-1:0]       valid_q;
  logic [ROBEntryWidth-1:0] tag_q [maxInst];
  logic [ROBEntryWidth-1:0] tag_d [maxInst];
  logic [2:0]               alloc_n, commit_m;
  logic                     grant, commit_ok, commit_bad;

  assign alloc_n  = enc_to_num(allocNum_i);
  assign commit_m = enc_to_num(commitNum_i);
  assign free     = CW'(DEPTH) - count_q;

  // Room is judged on start-of-cycle occupancy; a same-cycle commit never helps.
  assign grant      = allocReq_i && !flush_i && (free >= CW'(alloc_n));
  assign commit_ok  = commit_i && !flush_i && (CW'(commit_m) <= count_q);
  assign commit_bad = commit_i && !flush_i && !commit_ok;

  rob_ptr_adv #(.W(ROBEntryWidth)) u_tail_adv (.ptr(tail_q), .num(allocNum_i),  .next(tail_adv));
  rob_ptr_adv #(.W(ROBEntryWidth)) u_head_adv (.ptr(head_q), .num(commitNum_i), .next(head_adv));

  assign tag_d[0] = tail_q;
  for (genvar k = 1; k < maxInst; k++) begin : g_tag
    rob_ptr_adv #(.W(ROBEntryWidth)) u_tag_adv (
      .ptr  (tail_q),
      .num  (2'(k - 1)),
      .next (tag_d[k])
    );
  end

  // NOTE: give every always_comb output a default first so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (grant)     count_d = count_d + CW'(alloc_n);
    if (commit_ok) count_d = count_d - CW'(commit_m);
  end

  // NOTE: registers update with <= only, so every read in this block sees pre-edge values.
  // NOTE: the tag registers are few and visible at the ports, so they take a reset value too.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      grant_q <= 1'b0;
      stall_q <= 1'b0;
      valid_q <= '0;
      tag_q   <= '{default: '0};
    end else begin
      grant_q <= grant;
      stall_q <= allocReq_i && !flush_i && !grant;
      valid_q <= grant ? grant_mask(allocNum_i) : '0;
      if (grant)      tag_q <= tag_d;
      if (commit_bad) err_q <= 1'b1;
      if (flush_i) begin
        tail_q  <= head_q;
        count_q <= '0;
      end else begin
        if (grant)     tail_q <= tail_adv;
        if (commit_ok) head_q <= head_adv;
        count_q <= count_d;
      end
    end
  end

  assign allocGrant_o = grant_q;
  assign allocStall_o = stall_q;
  assign inst1Tag_o   = tag_q[0];
  assign inst2Tag_o   = tag_q[1];
  assign inst3Tag_o   = tag_q[2];
  assign inst4Tag_o   = tag_q[3];
  assign tagValid_o   = valid_q;
  assign headPtr_o    = head_q;
  assign freeCount_o  = free;
  assign full_o       = (count_q == CW'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign err_o        = err_q;

endmodule

// File: tb/tb_fx_rob_tag_allocator.sv
// Scoreboard bench for fx_rob_tag_allocator: a queue-of-tags ROB model predicts
// each cycle's registered outputs; a monitor pops and compares them after each edge.
module tb_fx_rob_tag_allocator;
  import fx_rob_tag_allocator_pkg::*;

  localparam int DEPTH = ROB_DEPTH;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       allocReq_i, commit_i, flush_i;
  logic [1:0] allocNum_i, commitNum_i;
  logic       allocGrant_o, allocStall_o, full_o, empty_o, err_o;
  logic [6:0] inst1Tag_o, inst2Tag_o, inst3Tag_o, inst4Tag_o, headPtr_o;
  logic [3:0] tagValid_o;
  logic [7:0] freeCount_o;

  fx_rob_tag_allocator dut (
    .clock_i      (clk),
    .reset_i      (reset_i),
    .allocReq_i   (allocReq_i),
    .allocNum_i   (allocNum_i),
    .commit_i     (commit_i),
    .commitNum_i  (commitNum_i),
    .flush_i      (flush_i),
    .allocGrant_o (allocGrant_o),
    .allocStall_o (allocStall_o),
    .inst1Tag_o   (inst1Tag_o),
    .inst2Tag_o   (inst2Tag_o),
    .inst3Tag_o   (inst3Tag_o),
    .inst4Tag_o   (inst4Tag_o),
    .tagValid_o   (tagValid_o),
    .headPtr_o    (headPtr_o),
    .freeCount_o  (freeCount_o),
    .full_o       (full_o),
    .empty_o      (empty_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       grant;
    bit       stall;
    bit [3:0] valid;
    bit [3:0] cmask;
    int       tag [4];
    int       head;
    int       free;
    bit       full;
    bit       empty;
    bit       err;
  } exp_t;

  exp_t     sb [$];
  int       total = 0;
  int       bad   = 0;

  // Reference model: the ROB is literally a queue of the tags in flight.
  int       rob [$];
  int       m_head, m_tail;
  bit       m_err;
  int       last_tag [4];
  bit [3:0] last_mask;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    rob.delete();
    m_head = 0;
    m_tail = 0;
    m_err = 1'b0;
    last_mask = '0;
    for (int k = 0; k < 4; k++) last_tag[k] = 0;
  endtask

  // Drive one cycle of stimulus and push the outputs expected after the next edge.
  task automatic cycle(input bit req, input int n, input bit com, input int m, input bit fl);
    exp_t e;
    int   cnt;
    @(negedge clk);
    allocReq_i  = req;
    allocNum_i  = 2'(n - 1);
    commit_i    = com;
    commitNum_i = 2'(m - 1);
    flush_i     = fl;
    cnt     = rob.size();
    e.grant = req && !fl && (DEPTH - cnt >= n);
    e.stall = req && !fl && !e.grant;
    if (fl) begin
      rob.delete();
      m_tail = m_head;
    end else begin
      if (com) begin
        if (m <= cnt) begin
          for (int i = 0; i < m; i++) void'(rob.pop_front());
          m_head = (m_head + m) % DEPTH;
        end else begin
          m_err = 1'b1;
        end
      end
      if (e.grant) begin
        for (int k = 0; k < n; k++) begin
          last_tag[k] = (m_tail + k) % DEPTH;
          rob.push_back(last_tag[k]);
        end
        m_tail = (m_tail + n) % DEPTH;
        last_mask = 4'((1 << n) - 1);
      end
    end
    e.valid = e.grant ? last_mask : 4'b0000;
    e.cmask = last_mask;
    for (int k = 0; k < 4; k++) e.tag[k] = last_tag[k];
    e.head  = m_head;
    e.free  = DEPTH - rob.size();
    e.full  = (rob.size() == DEPTH);
    e.empty = (rob.size() == 0);
    e.err   = m_err;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    allocReq_i = 0; allocNum_i = 0; commit_i = 0; commitNum_i = 0; flush_i = 0;
  endtask

  // Monitor: one expected record per clocked cycle, compared just after the edge.
  initial begin
    exp_t e;
    int   tags [4];
    forever begin
      @(posedge clk);
      #1;
      if (!reset_i && sb.size() > 0) begin
        e = sb.pop_front();
        tags[0] = int'(inst1Tag_o); tags[1] = int'(inst2Tag_o);
        tags[2] = int'(inst3Tag_o); tags[3] = int'(inst4Tag_o);
        check("grant", int'(allocGrant_o), int'(e.grant));
        check("stall", int'(allocStall_o), int'(e.stall));
        check("tag_valid", int'(tagValid_o), int'(e.valid));
        for (int k = 0; k < 4; k++)
          if (e.cmask[k]) check($sformatf("tag%0d", k + 1), tags[k], e.tag[k]);
        check("head", int'(headPtr_o), e.head);
        check("free_count", int'(freeCount_o), e.free);
        check("full", int'(full_o), int'(e.full));
        check("empty", int'(empty_o), int'(e.empty));
        check("err", int'(err_o), int'(e.err));
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_grant"}, int'(allocGrant_o), 0);
    check({tag, "_stall"}, int'(allocStall_o), 0);
    check({tag, "_valid"}, int'(tagValid_o), 0);
    check({tag, "_tag1"}, int'(inst1Tag_o), 0);
    check({tag, "_tag4"}, int'(inst4Tag_o), 0);
    check({tag, "_head"}, int'(headPtr_o), 0);
    check({tag, "_free"}, int'(freeCount_o), DEPTH);
    check({tag, "_empty"}, int'(empty_o), 1);
    check({tag, "_full"}, int'(full_o), 0);
    check({tag, "_err"}, int'(err_o), 0);
  endtask

  initial begin
    bit req, com, fl;
    int n, m, cnt;

    reset_i = 1'b1;
    idle_inputs();
    model_reset();
    #3;
    check_reset_state("reset");
    @(negedge clk);
    reset_i = 1'b0;

    // First group after reset: tags 0..3.
    cycle(1, 4, 0, 0, 0);
    // Fill to 126, refuse 4 at that level, then take the last two.
    for (int i = 0; i < 30; i++) cycle(1, 4, 0, 0, 0);
    cycle(1, 2, 0, 0, 0);
    cycle(1, 4, 0, 0, 0);
    cycle(1, 2, 0, 0, 0);
    // Full: a same-cycle commit does not open room for the request.
    cycle(1, 1, 1, 4, 0);
    cycle(1, 1, 0, 0, 0);

    // Drain, then walk head and tail to 126 for the wrap case.
    while (rob.size() > 0) cycle(0, 1, 1, min2(4, rob.size()), 0);
    while (m_tail != 126) cycle(1, min2(4, 126 - m_tail), 0, 0, 0);
    while (rob.size() > 0) cycle(0, 1, 1, min2(4, rob.size()), 0);
    cycle(1, 4, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);

    // Flush at count 10 with a request and a commit pending.
    cycle(1, 4, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 4, 1, 2, 1);
    cycle(1, 1, 0, 0, 0);

    // Over-commit sets the sticky error; an async reset clears it at once.
    cycle(1, 1, 0, 0, 0);
    cycle(0, 1, 1, 3, 0);
    cycle(0, 1, 0, 0, 0);
    @(negedge clk);
    idle_inputs();
    #2;
    reset_i = 1'b1;
    #1;
    check_reset_state("async_reset");
    sb.delete();
    model_reset();
    @(negedge clk);
    reset_i = 1'b0;

    for (int i = 0; i < 1500; i++) begin
      cnt = rob.size();
      req = ($urandom_range(99) < 60);
      n   = $urandom_range(4, 1);
      com = (cnt > 0) ? ($urandom_range(99) < 50) : ($urandom_range(99) < 2);
      m   = $urandom_range(4, 1);
      if (cnt > 0 && $urandom_range(99) >= 2) m = min2(m, cnt);
      fl  = ($urandom_range(99) < 2);
      cycle(req, n, com, m, fl);
    end

    @(negedge clk);
    idle_inputs();
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
